// File: rtl/mac_unit.sv
// Sequential 32-cycle shift-add multiplier with a running accumulator.
// MUL/MAC take 32 RUN cycles; CLRACC clears acc and result in one cycle.
module mac_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MAC    = 2'b01;
  localparam logic [1:0] OP_CLRACC = 2'b10;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;
  logic [31:0] acc;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] step_sum;
  logic [31:0] mac_sum;
  logic        ready;
  logic        long_op;

  always_comb begin
    step_sum = mplier[0] ? (prod + mcand) : prod;
    mac_sum  = acc + step_sum;
    ready    = (state == IDLE) || (state == DONE);
    long_op  = (op == OP_MUL) || (op == OP_MAC);
  end

  // While in reset the state is treated as IDLE, so only the request side matters.
  always_comb begin
    stall = 1'b0;
    if (rst)
      stall = start && long_op;
    else
      stall = busy || (ready && start && long_op);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      op_q   <= OP_MUL;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            case (op)
              OP_MUL, OP_MAC: begin
                mcand  <= a;
                mplier <= b;
                op_q   <= op;
                prod   <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_CLRACC: begin
                acc    <= '0;
                result <= '0;
                done   <= 1'b1;
                state  <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        RUN: begin
          prod   <= step_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          // The final step's partial sum is folded straight into the write-back.
          if (cnt == 6'd31) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (op_q == OP_MAC) begin
              result <= mac_sum;
              acc    <= mac_sum;
            end else begin
              result <= step_sum;
            end
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: stimulus pushes predicted results with due
// cycles, a negedge monitor checks done/result/busy/stall against them.
module tb_mac_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  mac_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy),
    .stall  (stall)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_lo = 0;
  int          busy_hi = -1;
  logic [31:0] acc_model = '0;
  logic [31:0] cur_result = '0;
  bit          checking = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Reference behaviour: a sequential multiply is just a*b arriving 33 cycles later.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [31:0] p;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    p     = x * y;
    if (!(cyc >= busy_lo && cyc <= busy_hi)) begin
      case (o)
        2'b00: begin
          e.res = p; e.due = cyc + 33; sb.push_back(e);
          busy_lo = cyc + 1; busy_hi = cyc + 32;
        end
        2'b01: begin
          acc_model = acc_model + p;
          e.res = acc_model; e.due = cyc + 33; sb.push_back(e);
          busy_lo = cyc + 1; busy_hi = cyc + 32;
        end
        2'b10: begin
          acc_model = '0;
          e.res = '0; e.due = cyc + 1; sb.push_back(e);
        end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    start = 1'b0;
    op    = 2'b11;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    sb.delete();
    busy_lo    = 0;
    busy_hi    = -1;
    acc_model  = '0;
    cur_result = '0;
    checking   = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic busy_exp;
    logic stall_exp;
    if (checking) begin
      busy_exp  = (cyc >= busy_lo && cyc <= busy_hi);
      stall_exp = rst ? (start && !op[1]) : (busy_exp || (start && !op[1]));
      checkOutput("busy", {31'b0, busy}, {31'b0, busy_exp});
      checkOutput("stall", {31'b0, stall}, {31'b0, stall_exp});
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", cyc, e.due);
          checkOutput("done_result", result, e.res);
          cur_result = e.res;
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checkOutput("missing_done", 32'd0, 32'd1);
        cur_result = e.res;
      end
      checkOutput("result_hold", result, cur_result);
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b11;
    a     = '0;
    b     = '0;
    @(posedge clk); #1;
    applyReset();

    $display("[TB] basic multiply");
    applyStimulus(2'b00, 32'd7, 32'd6);
    drain();
    applyStimulus(2'b01, 32'd1, 32'd0);
    drain();

    $display("[TB] negative operand");
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5);
    drain();

    $display("[TB] back-to-back MAC");
    applyStimulus(2'b10, 32'd0, 32'd0);
    applyStimulus(2'b01, 32'd2, 32'd3);
    idle(32);
    applyStimulus(2'b01, 32'd4, 32'd5);
    drain();

    $display("[TB] accumulator wrap");
    applyStimulus(2'b10, 32'd0, 32'd0);
    applyStimulus(2'b01, 32'd1, 32'd1);
    idle(32);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1);
    drain();
    applyStimulus(2'b01, 32'd1, 32'd1);
    drain();

    $display("[TB] start during RUN");
    applyStimulus(2'b00, 32'd5, 32'd5);
    idle(9);
    applyStimulus(2'b00, 32'd9, 32'd9);
    drain();

    $display("[TB] NOP");
    applyStimulus(2'b11, 32'd3, 32'd4);
    drain();

    $display("[TB] reset during RUN");
    applyStimulus(2'b00, 32'd8, 32'd8);
    idle(14);
    applyReset();
    idle(3);
    applyStimulus(2'b00, 32'd3, 32'd3);
    drain();

    $display("[TB] random traffic");
    repeat (30) begin
      idle($urandom_range(0, 40));
      applyStimulus(2'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
